// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate unit: one bit position per clock, start launches an
// operation from IDLE, done pulses for one cycle when Rz holds the result.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Rz,
  output logic [1:0]       fsm_state
);

  localparam logic [2:0] OP_SHL  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHRA = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] rem;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] amount;
  logic             unused_count_high;

  // Only the low CNT_W bits of count matter: the amount is taken modulo WIDTH.
  assign amount            = count[CNT_W-1:0];
  assign unused_count_high = ^count[WIDTH-1:CNT_W];

  function automatic logic [WIDTH-1:0] step(input logic [2:0] o, input logic [WIDTH-1:0] a);
    case (o)
      OP_SHL:  return {a[WIDTH-2:0], 1'b0};
      OP_SHR:  return {1'b0, a[WIDTH-1:1]};
      OP_SHRA: return {a[WIDTH-1], a[WIDTH-1:1]};
      OP_ROL:  return {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  return {a[0], a[WIDTH-1:1]};
      default: return a;
    endcase
  endfunction

  always_comb begin
    acc_next = step(op_q, acc);
  end

  // Handshake: start is sampled only in IDLE (no queueing); busy covers every
  // non-IDLE cycle and done is a one-cycle pulse during which Rz is valid.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_IDLE;
      acc   <= '0;
      rem   <= '0;
      op_q  <= '0;
      Rz    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc  <= Ra;
            rem  <= amount;
            op_q <= op;
            if ((amount == '0) || (op > OP_ROR)) begin
              Rz    <= Ra;
              state <= S_DONE;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          acc <= acc_next;
          rem <= rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            Rz    <= acc_next;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign fsm_state = state;

endmodule
